m_rr_arbiter_8: RTL and testbench

Eight-requester round-robin arbiter that shares one downstream resource, such as a one-hot-selected datapath slice or bus, between eight clients. It produces the 3-bit index of the current owner and the matching 8-bit one-hot grant, decoded internally. A hold timer forces rotation when a grant is held too long under contention. The block sits between the request sources and the one-hot select lines of the shared resource.

---
 rtl/m_rr_arbiter_8.sv | 105 ++++++++++
 tb/tb_m_rr_arbiter_8.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/m_rr_arbiter_8.sv
// Eight-requester round-robin arbiter with registered one-hot grant and a hold timer
// that forces rotation when the owner keeps the resource too long under contention.
module m_rr_arbiter_8 #(
  parameter int unsigned HOLD_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned CntW = $clog2(HOLD_LIMIT + 1);
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_LIMIT - 1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [2:0]      ptr_q, ptr_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] hold_q, hold_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;

  logic [2:0] pick;
  logic       pick_vld;
  logic       others_waiting;

  // Walk offsets from high to low so the smallest offset from ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[ptr_q + 3'(i)]) begin
        pick     = ptr_q + 3'(i);
        pick_vld = 1'b1;
      end
    end
  end

  assign others_waiting = |(req & ~(8'b1 << idx_q));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      idx_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_vld) begin
          idx_d   = pick;
          valid_d = 1'b1;
          hold_d  = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        // Release wins over preempt, so timeout only fires while the owner still requests.
        if (!req[idx_q]) begin
          valid_d = 1'b0;
          ptr_d   = idx_q + 3'd1;
          state_d = StIdle;
        end else if (hold_q == HoldMax && others_waiting) begin
          valid_d   = 1'b0;
          ptr_d     = idx_q + 3'd1;
          timeout_d = 1'b1;
          state_d   = StIdle;
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    gnt       = valid_q ? (8'b1 << idx_q) : 8'h00;
    gnt_idx   = idx_q;
    gnt_valid = valid_q;
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_m_rr_arbiter_8.sv
// Scoreboard bench for m_rr_arbiter_8: a cycle model pushes expected outputs per driven
// cycle; they are popped and compared one cycle later, plus directed scenario checks.
module tb_m_rr_arbiter_8;

  localparam int unsigned HoldLimit = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  m_rr_arbiter_8 #(.HOLD_LIMIT(HoldLimit)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: m_age counts cycles the current owner has already been visible.
  bit   m_valid = 0;
  bit   m_to = 0;
  int   m_idx = 0;
  int   m_ptr = 0;
  int   m_age = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic model_edge(input logic [7:0] r, input bit rst);
    exp_t       e;
    logic [7:0] own;
    bit         found;
    if (rst) begin
      m_valid = 0; m_to = 0; m_idx = 0; m_ptr = 0; m_age = 0;
    end else if (!m_valid) begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && r[(m_ptr + k) % 8]) begin
          found   = 1;
          m_idx   = (m_ptr + k) % 8;
          m_valid = 1;
          m_age   = 1;
        end
      end
    end else begin
      own  = 8'b1 << m_idx;
      m_to = 0;
      if ((r & own) == 8'h00) begin
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 8;
      end else if (m_age >= int'(HoldLimit) && (r & ~own) != 8'h00) begin
        m_valid = 0;
        m_ptr   = (m_idx + 1) % 8;
        m_to    = 1;
      end else begin
        m_age++;
      end
    end
    e.gnt   = m_valid ? (8'b1 << m_idx) : 8'h00;
    e.idx   = 3'(m_idx);
    e.valid = m_valid;
    e.to    = m_to;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [7:0] r, input bit rst);
    exp_t e;
    @(negedge clk);
    req   = r;
    reset = rst;
    model_edge(r, rst);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq("gnt", 32'(gnt), 32'(e.gnt));
      check_eq("gnt_idx", 32'(gnt_idx), 32'(e.idx));
      check_eq("gnt_valid", 32'(gnt_valid), 32'(e.valid));
      check_eq("timeout", 32'(timeout), 32'(e.to));
    end
  endtask

  initial begin
    int         n_grants;
    int         n_to;
    int         n_hi;
    bit         prev;
    logic [2:0] rec[9];
    logic [7:0] r;

    // Reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      step(8'hFF, 1'b1);
      check_eq("rst_gnt", 32'(gnt), 32'h00);
    end
    step(8'hFF, 1'b0);
    check_eq("first_grant", 32'(gnt), 32'h01);
    step(8'h00, 1'b0);

    // Single client
    step(8'h20, 1'b0);
    check_eq("single_gnt", 32'(gnt), 32'h20);
    check_eq("single_idx", 32'(gnt_idx), 32'd5);
    step(8'h20, 1'b0);
    step(8'h00, 1'b0);
    check_eq("single_drop", 32'(gnt), 32'h00);
    step(8'h20, 1'b0);
    check_eq("single_regrant", 32'(gnt), 32'h20);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Full contention from a fresh pointer
    step(8'hFF, 1'b1);
    n_grants = 0; n_to = 0; prev = 0;
    for (int i = 0; i < 41; i++) begin
      step(8'hFF, 1'b0);
      if (gnt_valid && !prev) begin
        if (n_grants < 9) rec[n_grants] = gnt_idx;
        n_grants++;
      end
      if (timeout) n_to++;
      prev = gnt_valid;
    end
    check_eq("cont_grants", 32'(n_grants), 32'd9);
    for (int k = 0; k < 9; k++) check_eq("cont_order", 32'(rec[k]), 32'(k % 8));
    check_eq("cont_timeouts", 32'(n_to), 32'd8);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Pointer wrap 6 -> 7 -> 0
    step(8'h40, 1'b0);
    check_eq("wrap_g6", 32'(gnt_idx), 32'd6);
    step(8'h00, 1'b0);
    step(8'h81, 1'b0);
    check_eq("wrap_g7", 32'(gnt), 32'h80);
    step(8'h81, 1'b0);
    step(8'h01, 1'b0);
    step(8'h01, 1'b0);
    check_eq("wrap_g0", 32'(gnt), 32'h01);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Uncontended hold
    n_hi = 0; n_to = 0;
    for (int i = 0; i < 40; i++) begin
      step(8'h08, 1'b0);
      if (gnt == 8'h08) n_hi++;
      if (timeout) n_to++;
    end
    check_eq("hold_cycles", 32'(n_hi), 32'd40);
    check_eq("hold_timeouts", 32'(n_to), 32'd0);
    step(8'h00, 1'b0);
    step(8'h00, 1'b0);

    // Release on the same edge the hold limit would preempt
    for (int i = 0; i < 4; i++) step(8'h18, 1'b0);
    check_eq("simul_owner", 32'(gnt), 32'h10);
    step(8'h08, 1'b0);
    check_eq("simul_dead_gnt", 32'(gnt), 32'h00);
    check_eq("simul_dead_to", 32'(timeout), 32'd0);
    step(8'h08, 1'b0);
    check_eq("simul_next", 32'(gnt_idx), 32'd3);
    step(8'h00, 1'b0);

    // Random traffic, occasional mid-grant reset
    for (int i = 0; i < 200; i++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
      step(r, $urandom_range(0, 39) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
